// File: rtl/id_stage_ctrl.sv
// ID-stage controller: decodes the fetched instruction, fills the ID/EX register and sequences
// load-use bubbles and post-redirect kill slots. Optional perf counters under `ID_PERF_CNT_EN.
module id_stage_ctrl #(
   parameter int LOAD_LAT     = 1,
   parameter int FLUSH_CYCLES = 1
`ifdef ID_PERF_CNT_EN
   ,
   parameter int CNT_W        = 32
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   input  logic [31:0] if_inst,
   input  logic        ex_redirect,
   output logic        id_ready,
   output logic        idex_valid,
   output logic [31:0] idex_inst,
   output logic [2:0]  idex_immsel,
   output logic [4:0]  idex_rd,
   output logic        idex_memrd,
   output logic        idex_illegal
`ifdef ID_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_stall,
   output logic [CNT_W-1:0] perf_flush
`endif
);

   typedef enum logic [1:0] {RUN, LU_STALL, KILL} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        idex_valid_q, idex_valid_d;
   logic [31:0] idex_inst_q, idex_inst_d;
   logic [2:0]  idex_immsel_q, idex_immsel_d;
   logic [4:0]  idex_rd_q, idex_rd_d;
   logic        idex_memrd_q, idex_memrd_d;
   logic        idex_illegal_q, idex_illegal_d;

   logic [2:0]  dec_sel;
   logic [4:0]  dec_rd;
   logic        dec_memrd, dec_ill, rs1_used, rs2_used;
   logic        hazard, load;

   always_comb begin
      dec_sel   = 3'd7;
      dec_memrd = 1'b0;
      dec_ill   = 1'b0;
      rs2_used  = 1'b0;
      case (if_inst[6:0])
         7'b0010011, 7'b1100111: dec_sel = 3'd0;
         7'b0000011: begin
            dec_sel   = 3'd0;
            dec_memrd = 1'b1;
         end
         7'b0100011: begin
            dec_sel  = 3'd1;
            rs2_used = 1'b1;
         end
         7'b1100011: begin
            dec_sel  = 3'd2;
            rs2_used = 1'b1;
         end
         7'b0110111, 7'b0010111: dec_sel = 3'd3;
         7'b1101111: dec_sel = 3'd4;
         7'b1110011: dec_sel = if_inst[14] ? 3'd5 : 3'd7;
         7'b0110011: rs2_used = 1'b1;
         default:    dec_ill = 1'b1;
      endcase
      rs1_used = !(dec_sel == 3'd3 || dec_sel == 3'd4 || dec_sel == 3'd5);
      dec_rd   = (dec_sel == 3'd1 || dec_sel == 3'd2) ? 5'd0 : if_inst[11:7];
   end

   // The qualifying valid/memrd/rd!=0 terms keep bubbles and x0 loads from ever stalling.
   assign hazard = idex_valid_q & idex_memrd_q & (idex_rd_q != 5'd0) & if_valid &
                   ((rs1_used & (if_inst[19:15] == idex_rd_q)) |
                    (rs2_used & (if_inst[24:20] == idex_rd_q)));

   // The hazard-entry cycle is the first bubble; LU_STALL holds the remaining LOAD_LAT-1.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      id_ready = 1'b0;
      load     = 1'b0;
      case (state_q)
         RUN: begin
            if (ex_redirect) begin
               state_d = KILL;
               cnt_d   = 2'(FLUSH_CYCLES - 1);
            end else if (hazard) begin
               if (LOAD_LAT > 1) begin
                  state_d = LU_STALL;
                  cnt_d   = 2'(LOAD_LAT - 2);
               end
            end else begin
               id_ready = 1'b1;
               load     = if_valid;
            end
         end
         LU_STALL: begin
            if (ex_redirect) begin
               state_d = KILL;
               cnt_d   = 2'(FLUSH_CYCLES - 1);
            end else if (cnt_q == 2'd0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         KILL: begin
            id_ready = 1'b1;
            if (ex_redirect) begin
               cnt_d = 2'(FLUSH_CYCLES - 1);
            end else if (cnt_q == 2'd0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      idex_valid_d   = load;
      idex_inst_d    = idex_inst_q;
      idex_immsel_d  = idex_immsel_q;
      idex_rd_d      = idex_rd_q;
      idex_memrd_d   = idex_memrd_q;
      idex_illegal_d = idex_illegal_q;
      if (load) begin
         idex_inst_d    = if_inst;
         idex_immsel_d  = dec_sel;
         idex_rd_d      = dec_rd;
         idex_memrd_d   = dec_memrd;
         idex_illegal_d = dec_ill;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         cnt_q          <= 2'd0;
         idex_valid_q   <= 1'b0;
         idex_inst_q    <= 32'h0000_0013;
         idex_immsel_q  <= 3'd0;
         idex_rd_q      <= 5'd0;
         idex_memrd_q   <= 1'b0;
         idex_illegal_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idex_valid_q   <= idex_valid_d;
         idex_inst_q    <= idex_inst_d;
         idex_immsel_q  <= idex_immsel_d;
         idex_rd_q      <= idex_rd_d;
         idex_memrd_q   <= idex_memrd_d;
         idex_illegal_q <= idex_illegal_d;
      end
   end

   assign idex_valid   = idex_valid_q;
   assign idex_inst    = idex_inst_q;
   assign idex_immsel  = idex_immsel_q;
   assign idex_rd      = idex_rd_q;
   assign idex_memrd   = idex_memrd_q;
   assign idex_illegal = idex_illegal_q;

`ifdef ID_PERF_CNT_EN
   logic [CNT_W-1:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;
   logic             stall_inc, flush_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      sat_inc = (en && v != {CNT_W{1'b1}}) ? v + 1'b1 : v;
   endfunction

   assign stall_inc = (state_q == LU_STALL) | ((state_q == RUN) & !ex_redirect & hazard);
   assign flush_inc = (state_q == KILL) & if_valid;

   always_comb begin
      perf_stall_d = sat_inc(perf_stall_q, stall_inc);
      perf_flush_d = sat_inc(perf_flush_q, flush_inc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall = perf_stall_q;
   assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Scoreboard bench for id_stage_ctrl: dut1 uses LOAD_LAT=1/FLUSH_CYCLES=1, dut2 uses 2/2.
module tb_id_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] if_inst = 32'h0;
   logic        ex_redirect = 1'b0;

   logic        rdy1, vld1, mr1, ill1, rdy2, vld2, mr2, ill2;
   logic [31:0] inst1, inst2;
   logic [2:0]  sel1, sel2;
   logic [4:0]  rd1, rd2;

   always #5 clk = ~clk;

`ifdef ID_PERF_CNT_EN
   logic [31:0] ps1, pf1, ps2, pf2;
`endif

   id_stage_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst),
      .ex_redirect(ex_redirect), .id_ready(rdy1), .idex_valid(vld1), .idex_inst(inst1),
      .idex_immsel(sel1), .idex_rd(rd1), .idex_memrd(mr1), .idex_illegal(ill1)
`ifdef ID_PERF_CNT_EN
      , .perf_stall(ps1), .perf_flush(pf1)
`endif
   );

   id_stage_ctrl #(.LOAD_LAT(2), .FLUSH_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst),
      .ex_redirect(ex_redirect), .id_ready(rdy2), .idex_valid(vld2), .idex_inst(inst2),
      .idex_immsel(sel2), .idex_rd(rd2), .idex_memrd(mr2), .idex_illegal(ill2)
`ifdef ID_PERF_CNT_EN
      , .perf_stall(ps2), .perf_flush(pf2)
`endif
   );

   logic        phase = 1'b0;
   logic        mon_en = 1'b0;
   logic        m_rdy, m_vld, m_mr, m_ill;
   logic [31:0] m_inst;
   logic [2:0]  m_sel;
   logic [4:0]  m_rd;

   assign m_rdy  = phase ? rdy2  : rdy1;
   assign m_vld  = phase ? vld2  : vld1;
   assign m_inst = phase ? inst2 : inst1;
   assign m_sel  = phase ? sel2  : sel1;
   assign m_rd   = phase ? rd2   : rd1;
   assign m_mr   = phase ? mr2   : mr1;
   assign m_ill  = phase ? ill2  : ill1;

   typedef struct packed {
      logic [31:0] due;
      logic [31:0] inst;
      logic [2:0]  sel;
      logic [4:0]  rd;
      logic        mr;
      logic        ill;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].due < cyc) begin
            n_chk++;
            n_err++;
            $display("FAIL missing_idex: got nothing required inst %h at cycle %0d", sb[0].inst, sb[0].due);
            void'(sb.pop_front());
         end
         if (m_vld) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_idex: got inst %h required no valid (cycle %0d)", m_inst, cyc);
            end else begin
               e = sb.pop_front();
               chk("idex_cycle", cyc, e.due);
               chk("idex_inst", m_inst, e.inst);
               chk("idex_decode", {22'd0, m_ill, m_mr, m_rd, m_sel}, {22'd0, e.ill, e.mr, e.rd, e.sel});
            end
         end
      end
   end

   // One IF slot: drive, check id_ready mid-cycle, and queue the expected ID/EX contents.
   task automatic step(input logic v, input logic [31:0] inst, input logic redir, input logic rdy,
                       input logic keep, input logic [2:0] sel, input logic [4:0] rd,
                       input logic mr, input logic ill);
      exp_t e;
      if_valid    = v;
      if_inst     = inst;
      ex_redirect = redir;
      @(negedge clk);
      chk("id_ready", {31'd0, m_rdy}, {31'd0, rdy});
      if (keep) begin
         e = '{due: cyc + 1, inst: inst, sel: sel, rd: rd, mr: mr, ill: ill};
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rst_valid",  {31'd0, m_vld}, 32'd0);
      chk("rst_inst",   m_inst, 32'h0000_0013);
      chk("rst_ready",  {31'd0, m_rdy}, 32'd1);
      chk("rst_fields", {23'd0, m_ill, m_mr, m_rd, m_sel}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals();
`ifdef ID_PERF_CNT_EN
      chk("rst_perf", ps1 | pf1, 32'd0);
`endif
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // dut1: decode stream, illegal opcode
      step(1, 32'h60010113, 0, 1, 1, 3'd0, 5'd2, 0, 0);
      step(1, 32'h00e12423, 0, 1, 1, 3'd1, 5'd0, 0, 0);
      step(1, 32'h00208863, 0, 1, 1, 3'd2, 5'd0, 0, 0);
      step(1, 32'h005412b7, 0, 1, 1, 3'd3, 5'd5, 0, 0);
      step(1, 32'h00c000ef, 0, 1, 1, 3'd4, 5'd1, 0, 0);
      step(1, 32'h51e0d073, 0, 1, 1, 3'd5, 5'd0, 0, 0);
      step(1, 32'h003100b3, 0, 1, 1, 3'd7, 5'd1, 0, 0);
      step(1, 32'h0000007f, 0, 1, 1, 3'd7, 5'd0, 0, 1);
      // load-use on rs1: one bubble
      step(1, 32'h00012283, 0, 1, 1, 3'd0, 5'd5, 1, 0);
      step(1, 32'h00128333, 0, 0, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00128333, 0, 1, 1, 3'd7, 5'd6, 0, 0);
      // no hazard: load to x0, and lui whose rs1 field equals the load rd
      step(1, 32'h00012003, 0, 1, 1, 3'd0, 5'd0, 1, 0);
      step(1, 32'h00100333, 0, 1, 1, 3'd7, 5'd6, 0, 0);
      step(1, 32'h00012283, 0, 1, 1, 3'd0, 5'd5, 1, 0);
      step(1, 32'h000282b7, 0, 1, 1, 3'd3, 5'd5, 0, 0);
      // load-use on rs2
      step(1, 32'h00012083, 0, 1, 1, 3'd0, 5'd1, 1, 0);
      step(1, 32'h00128333, 0, 0, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00128333, 0, 1, 1, 3'd7, 5'd6, 0, 0);
      step(0, 32'h00000000, 0, 1, 0, 3'd0, 5'd0, 0, 0);
      // redirect: one slot killed; redirect beats a coincident hazard
      step(1, 32'h60010113, 0, 1, 1, 3'd0, 5'd2, 0, 0);
      step(1, 32'h00e12423, 1, 0, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00e12423, 0, 1, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00208863, 0, 1, 1, 3'd2, 5'd0, 0, 0);
      step(1, 32'h00012283, 0, 1, 1, 3'd0, 5'd5, 1, 0);
      step(1, 32'h00128333, 1, 0, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00128333, 0, 1, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h000282b7, 0, 1, 1, 3'd3, 5'd5, 0, 0);
      step(0, 32'h00000000, 0, 1, 0, 3'd0, 5'd0, 0, 0);
`ifdef ID_PERF_CNT_EN
      chk("perf_stall1", ps1, 32'd2);
      chk("perf_flush1", pf1, 32'd2);
`endif
      chk("sb_empty_a", sb.size(), 32'd0);

      // reset with live data in ID/EX
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk_reset_vals();
      sb.delete();
      phase  = 1'b1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // dut2: two bubbles, two killed slots, redirect abandoning a stall
      step(1, 32'h00012283, 0, 1, 1, 3'd0, 5'd5, 1, 0);
      step(1, 32'h00128333, 0, 0, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00128333, 0, 0, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00128333, 0, 1, 1, 3'd7, 5'd6, 0, 0);
      step(1, 32'h60010113, 0, 1, 1, 3'd0, 5'd2, 0, 0);
      step(1, 32'h00e12423, 1, 0, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00e12423, 0, 1, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00208863, 0, 1, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h000282b7, 0, 1, 1, 3'd3, 5'd5, 0, 0);
      step(1, 32'h00012283, 0, 1, 1, 3'd0, 5'd5, 1, 0);
      step(1, 32'h00128333, 0, 0, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00128333, 1, 0, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00128333, 0, 1, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00c000ef, 0, 1, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00c000ef, 0, 1, 1, 3'd4, 5'd1, 0, 0);
      step(0, 32'h00000000, 0, 1, 0, 3'd0, 5'd0, 0, 0);
      step(1, 32'h00012283, 0, 1, 1, 3'd0, 5'd5, 1, 0);
      step(1, 32'h00128333, 0, 0, 0, 3'd0, 5'd0, 0, 0);
`ifdef ID_PERF_CNT_EN
      chk("perf_stall2", ps2, 32'd5);
      chk("perf_flush2", pf2, 32'd4);
`endif
      // reset in the middle of a load-use stall: no bubble may survive
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk_reset_vals();
      sb.delete();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      step(1, 32'h00128333, 0, 1, 1, 3'd7, 5'd6, 0, 0);
      step(0, 32'h00000000, 0, 1, 0, 3'd0, 5'd0, 0, 0);
      step(0, 32'h00000000, 0, 1, 0, 3'd0, 5'd0, 0, 0);
      chk("sb_empty_b", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
